// File: rtl/controller_poller_if.sv
// controller_poller_if: pad-side signals shared by both serial game controllers.
// The poller drives latch and shift strobe; each controller returns one active-low data line.
interface controller_poller_if;
   logic controller_latch;
   logic controller_clk_out_enable;
   logic controller_1_data_in_B;
   logic controller_2_data_in_B;

   modport master (
      output controller_latch,
      output controller_clk_out_enable,
      input  controller_1_data_in_B,
      input  controller_2_data_in_B
   );

   modport slave (
      input  controller_latch,
      input  controller_clk_out_enable,
      output controller_1_data_in_B,
      output controller_2_data_in_B
   );
endinterface

// File: rtl/controller_poller.sv
// controller_poller: once per frame latches, shifts and samples both controllers, then
// publishes both button bytes atomically. Optional debounce: CONTROLLER_POLLER_DEBOUNCE_EN.
module controller_poller #(
   parameter int BITS        = 8,
   parameter int LATCH_TICKS = 2
) (
   input  logic                clk_5,
   input  logic                rst_B,
   input  logic                clk_in_enable,
   input  logic                vsync,
   controller_poller_if.master pad,
   output logic [BITS-1:0]     controller_1_buttons_out,
   output logic [BITS-1:0]     controller_2_buttons_out,
   output logic                buttons_valid,
   output logic                busy
);
   localparam int LCW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;
   localparam int BCW = (BITS > 1) ? $clog2(BITS) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LATCH  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [LCW-1:0] LATCH_LAST = LCW'(LATCH_TICKS - 1);
   localparam logic [BCW-1:0] BIT_LAST   = BCW'(BITS - 1);

   logic [1:0]      state_q, state_d;
   logic [LCW-1:0]  latch_cnt_q, latch_cnt_d;
   logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
   logic            pend_q, pend_d;
   logic            vsync_q;
   logic            latch_q, latch_d;
   logic            strobe_q, strobe_d;
   logic            valid_q, valid_d;
   logic [BITS-1:0] shift1_q, shift1_d, shift2_q, shift2_d;
   logic [BITS-1:0] out1_q, out1_d, out2_q, out2_d;
   logic [BITS-1:0] new1, new2;
   logic            frame_req;

`ifdef CONTROLLER_POLLER_DEBOUNCE_EN
   logic [BITS-1:0] raw1_q, raw1_d, raw2_q, raw2_d;

   // A bit is accepted only when two consecutive polls agree on it.
   function automatic logic [BITS-1:0] settle(input logic [BITS-1:0] nw,
                                              input logic [BITS-1:0] prev,
                                              input logic [BITS-1:0] held);
      logic [BITS-1:0] agree;
      agree = ~(nw ^ prev);
      return (nw & agree) | (held & ~agree);
   endfunction
`endif

   assign frame_req = vsync_q & ~vsync;
   assign new1      = {shift1_q[BITS-2:0], ~pad.controller_1_data_in_B};
   assign new2      = {shift2_q[BITS-2:0], ~pad.controller_2_data_in_B};

   always_comb begin
      state_d     = state_q;
      latch_cnt_d = latch_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      pend_d      = pend_q;
      latch_d     = latch_q;
      strobe_d    = 1'b0;
      valid_d     = 1'b0;
      shift1_d    = shift1_q;
      shift2_d    = shift2_q;
      out1_d      = out1_q;
      out2_d      = out2_q;
`ifdef CONTROLLER_POLLER_DEBOUNCE_EN
      raw1_d      = raw1_q;
      raw2_d      = raw2_q;
`endif
      case (state_q)
         IDLE: begin
            if (frame_req || pend_q) begin
               state_d     = LATCH;
               latch_cnt_d = '0;
               pend_d      = 1'b0;
               latch_d     = 1'b1;
            end
         end
         LATCH: begin
            if (frame_req) pend_d = 1'b1;
            if (clk_in_enable) begin
               if (latch_cnt_q == LATCH_LAST) begin
                  latch_d   = 1'b0;
                  state_d   = SAMPLE;
                  bit_cnt_d = '0;
               end else begin
                  latch_cnt_d = latch_cnt_q + LCW'(1);
               end
            end
         end
         SAMPLE: begin
            if (frame_req) pend_d = 1'b1;
            if (clk_in_enable) begin
               shift1_d = new1;
               shift2_d = new2;
               // Outputs load on the edge into DONE so valid and data appear together.
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = DONE;
                  valid_d = 1'b1;
`ifdef CONTROLLER_POLLER_DEBOUNCE_EN
                  out1_d  = settle(new1, raw1_q, out1_q);
                  out2_d  = settle(new2, raw2_q, out2_q);
                  raw1_d  = new1;
                  raw2_d  = new2;
`else
                  out1_d  = new1;
                  out2_d  = new2;
`endif
               end else begin
                  strobe_d  = 1'b1;
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         default: begin
            if (pend_q || frame_req) begin
               state_d     = LATCH;
               latch_cnt_d = '0;
               pend_d      = 1'b0;
               latch_d     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_5 or negedge rst_B) begin
      if (!rst_B) begin
         state_q     <= IDLE;
         latch_cnt_q <= '0;
         bit_cnt_q   <= '0;
         pend_q      <= 1'b0;
         vsync_q     <= 1'b0;
         latch_q     <= 1'b0;
         strobe_q    <= 1'b0;
         valid_q     <= 1'b0;
         shift1_q    <= '0;
         shift2_q    <= '0;
         out1_q      <= '0;
         out2_q      <= '0;
`ifdef CONTROLLER_POLLER_DEBOUNCE_EN
         raw1_q      <= '0;
         raw2_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         latch_cnt_q <= latch_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         pend_q      <= pend_d;
         vsync_q     <= vsync;
         latch_q     <= latch_d;
         strobe_q    <= strobe_d;
         valid_q     <= valid_d;
         shift1_q    <= shift1_d;
         shift2_q    <= shift2_d;
         out1_q      <= out1_d;
         out2_q      <= out2_d;
`ifdef CONTROLLER_POLLER_DEBOUNCE_EN
         raw1_q      <= raw1_d;
         raw2_q      <= raw2_d;
`endif
      end
   end

   assign pad.controller_latch          = latch_q;
   assign pad.controller_clk_out_enable = strobe_q;
   assign controller_1_buttons_out      = out1_q;
   assign controller_2_buttons_out      = out2_q;
   assign buttons_valid                 = valid_q;
   assign busy                          = (state_q != IDLE);
endmodule

// File: tb/tb_controller_poller.sv
// tb_controller_poller: scoreboard bench with behavioural serial controllers for controller_poller.
// Honours CONTROLLER_POLLER_DEBOUNCE_EN in its expected-value model.
`timescale 1ns/1ps
module tb_controller_poller;
   localparam int BITS = 8;
   localparam int LT   = 2;

   logic            clk_5 = 1'b0;
   logic            rst_B = 1'b0;
   logic            clk_in_enable = 1'b0;
   logic            vsync = 1'b0;
   logic [BITS-1:0] b1, b2;
   logic            buttons_valid, busy;

   controller_poller_if pad();

   controller_poller #(.BITS(BITS), .LATCH_TICKS(LT)) dut (
      .clk_5                    (clk_5),
      .rst_B                    (rst_B),
      .clk_in_enable            (clk_in_enable),
      .vsync                    (vsync),
      .pad                      (pad),
      .controller_1_buttons_out (b1),
      .controller_2_buttons_out (b2),
      .buttons_valid            (buttons_valid),
      .busy                     (busy)
   );

   always #5 clk_5 = ~clk_5;

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard and expected-value model
   logic [BITS-1:0] q1[$], q2[$];
   logic [BITS-1:0] m_out1 = '0, m_out2 = '0, m_raw1 = '0, m_raw2 = '0;

   function automatic logic [BITS-1:0] model_out(input logic [BITS-1:0] nw,
                                                 input logic [BITS-1:0] prev,
                                                 input logic [BITS-1:0] held);
      logic [BITS-1:0] r;
`ifdef CONTROLLER_POLLER_DEBOUNCE_EN
      for (int i = 0; i < BITS; i++) r[i] = (nw[i] == prev[i]) ? nw[i] : held[i];
`else
      r = nw;
      if (prev == held) r = nw;
`endif
      return r;
   endfunction

   task automatic expect_poll(input logic [BITS-1:0] r1, input logic [BITS-1:0] r2);
      m_out1 = model_out(r1, m_raw1, m_out1);
      m_out2 = model_out(r2, m_raw2, m_out2);
      m_raw1 = r1;
      m_raw2 = r2;
      q1.push_back(m_out1);
      q2.push_back(m_out2);
   endtask

   // Shared state between the stimulus and the monitor/controller-model process
   logic [BITS-1:0] btn1 = '0, btn2 = '0;
   int tick_period = 100;
   int tick_cnt = 0;
   int cyc = 0;
   int idx = 0;
   int nstrobe = 0, nlt = 0, nvalid = 0, noverlap = 0;
   int lat_cnt = 0, lat_exp = 0;
   bit lat_arm = 0, lat_run = 0, vs_prev = 0, fr = 0;
   logic [BITS-1:0] last1 = '0, last2 = '0, e1, e2;

   initial begin : monitor
      forever begin
         @(negedge clk_5);
         cyc++;
         fr = 1'b0;
         if (!rst_B) begin
            idx = 0; nstrobe = 0; nlt = 0; lat_run = 0;
            last1 = '0; last2 = '0;
         end else begin
            if (buttons_valid) begin
               nvalid++;
               if (q1.size() == 0) begin
                  check_eq("unexpected_valid", 32'(nvalid), 32'(nvalid - 1));
               end else begin
                  e1 = q1.pop_front();
                  e2 = q2.pop_front();
                  check_eq("buttons_1", 32'(b1), 32'(e1));
                  check_eq("buttons_2", 32'(b2), 32'(e2));
               end
               check_eq("strobe_count", 32'(nstrobe), 32'(BITS - 1));
               check_eq("latch_ticks", 32'(nlt), 32'(LT));
               if (lat_run) begin
                  check_eq("latency", 32'(cyc), 32'(lat_exp));
                  lat_run = 0;
               end
               nstrobe = 0;
               nlt = 0;
            end else if (b1 !== last1 || b2 !== last2) begin
               check_eq("outputs_stable", {16'h0, b1, b2}, {16'h0, last1, last2});
            end
            last1 = b1;
            last2 = b2;
            if (pad.controller_clk_out_enable) nstrobe++;
            fr = vs_prev && !vsync;
            if (fr && lat_arm) begin
               lat_run = 1; lat_arm = 0; lat_cnt = 0;
            end
            if (pad.controller_latch) idx = 0;
            else if (pad.controller_clk_out_enable && idx < BITS - 1) idx++;
         end
         vs_prev = vsync;
         pad.controller_1_data_in_B = ~btn1[BITS-1-idx];
         pad.controller_2_data_in_B = ~btn2[BITS-1-idx];
         tick_cnt = (tick_cnt >= tick_period - 1) ? 0 : tick_cnt + 1;
         clk_in_enable = (tick_cnt == 0);
         if (rst_B && clk_in_enable) begin
            if (pad.controller_latch) nlt++;
            if (pad.controller_clk_out_enable) noverlap++;
            if (lat_run && !fr) begin
               lat_cnt++;
               if (lat_cnt == LT + BITS) lat_exp = cyc + 1;
            end
         end
      end
   end

   task automatic vsync_fall();
      @(posedge clk_5); #2 vsync = 1'b1;
      @(posedge clk_5); #2 vsync = 1'b0;
   endtask

   task automatic start_poll(input logic [BITS-1:0] c1, input logic [BITS-1:0] c2);
      btn1 = c1;
      btn2 = c2;
      expect_poll(c1, c2);
      vsync_fall();
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((q1.size() != 0 || busy) && n < 5000) begin
         @(posedge clk_5); #1;
         n++;
      end
      repeat (3) @(posedge clk_5);
      #1 check_eq(tag, 32'(q1.size()), 32'd0);
   endtask

   task automatic wait_strobes(input int n, input string tag);
      int k = 0;
      while (nstrobe < n && k < 5000) begin
         @(posedge clk_5); #1;
         k++;
      end
      check_eq(tag, 32'(nstrobe >= n), 32'd1);
   endtask

   task automatic reset_clear();
      q1.delete(); q2.delete();
      m_out1 = '0; m_out2 = '0; m_raw1 = '0; m_raw2 = '0;
   endtask

   int v0;

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      repeat (4) @(posedge clk_5);
      #1;
      check_eq("rst_latch",  32'(pad.controller_latch), 32'd0);
      check_eq("rst_strobe", 32'(pad.controller_clk_out_enable), 32'd0);
      check_eq("rst_b1",     32'(b1), 32'd0);
      check_eq("rst_b2",     32'(b2), 32'd0);
      check_eq("rst_valid",  32'(buttons_valid), 32'd0);
      check_eq("rst_busy",   32'(busy), 32'd0);
      @(posedge clk_5); #2 rst_B = 1'b1;
      repeat (5) @(posedge clk_5);

      // Basic poll with latency measurement
      lat_arm = 1;
      start_poll(8'h89, 8'h26);
      wait_idle("basic_drain");
      check_eq("latency_measured", 32'(lat_run), 32'd0);

      // Controller 1 data changes mid-shift: bits 7..4 from 0x89, bits 3..0 from 0x00
      btn2 = 8'h26;
      btn1 = 8'h89;
      expect_poll(8'h80, 8'h26);
      vsync_fall();
      wait_strobes(4, "atomic_wait");
      @(posedge clk_5); #2 btn1 = 8'h00;
      wait_idle("atomic_drain");

      // Pending request: second edge during SAMPLE honoured, third dropped
      v0 = nvalid;
      start_poll(8'h5A, 8'hA5);
      wait_strobes(2, "pending_wait");
      expect_poll(8'h5A, 8'hA5);
      vsync_fall();
      repeat (5) @(posedge clk_5);
      vsync_fall();
      wait_idle("pending_drain");
      check_eq("pending_valids", 32'(nvalid - v0), 32'd2);

      // Reset mid-poll during bit 4
      start_poll(8'hC3, 8'h3C);
      wait_strobes(4, "reset_wait");
      @(posedge clk_5); #2 rst_B = 1'b0;
      #1;
      check_eq("midrst_latch",  32'(pad.controller_latch), 32'd0);
      check_eq("midrst_strobe", 32'(pad.controller_clk_out_enable), 32'd0);
      check_eq("midrst_busy",   32'(busy), 32'd0);
      check_eq("midrst_b1",     32'(b1), 32'd0);
      check_eq("midrst_b2",     32'(b2), 32'd0);
      reset_clear();
      repeat (3) @(posedge clk_5);
      #2 rst_B = 1'b1;
      repeat (3) @(posedge clk_5);
      lat_arm = 1;
      start_poll(8'h89, 8'h26);
      wait_idle("recovery_drain");

      // Fastest tick rate
      @(posedge clk_5); #2 tick_period = 2;
      start_poll(8'hF0, 8'h0F);
      wait_idle("fast1_drain");
      start_poll(8'hFF, 8'h01);
      wait_idle("fast2_drain");
      check_eq("strobe_tick_overlap", 32'(noverlap), 32'd0);

`ifdef CONTROLLER_POLLER_DEBOUNCE_EN
      @(posedge clk_5); #2 rst_B = 1'b0;
      reset_clear();
      repeat (3) @(posedge clk_5);
      #2 rst_B = 1'b1;
      repeat (3) @(posedge clk_5);
      start_poll(8'h89, 8'h26);
      wait_idle("deb1_drain");
      check_eq("deb_poll1", 32'(b1), 32'h00);
      start_poll(8'h89, 8'h26);
      wait_idle("deb2_drain");
      check_eq("deb_poll2", 32'(b1), 32'h89);
      start_poll(8'h88, 8'h26);
      wait_idle("deb3_drain");
      check_eq("deb_poll3", 32'(b1), 32'h89);
      start_poll(8'h88, 8'h26);
      wait_idle("deb4_drain");
      check_eq("deb_poll4", 32'(b1), 32'h88);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/controller_poller.md
Name: controller_poller

Overview:
- Frame-synchronous sequencer for the two serial game controllers.
- Once per video frame, triggered by the vsync falling edge, it drives the controller latch and shift-clock strobes and samples both active-low serial data lines.
- Assembles two button bytes and publishes them atomically, so CPU reads at 0x7002/0x7003 never see a half-shifted value.
- Runs on the system clock; serial timing comes from a slow tick enable.

Parameters:
- BITS, 8, buttons per controller; sets shift-register and output width.
- LATCH_TICKS, 2, number of clk_in_enable ticks the latch is held high.

Ports:
- clk_5  input  1  system clock.
- rst_B  input  1  asynchronous, active-low reset.
- clk_in_enable  input  1  serial timing tick; one clk_5 cycle wide; period ≥2 clk_5 cycles.
- vsync  input  1  video vsync (active level irrelevant); falling edge requests a poll.
- controller_1_data_in_B  input  1  serial data, controller 1, active-low.
- controller_2_data_in_B  input  1  serial data, controller 2, active-low.
- controller_latch  output  1  parallel-load strobe to both controllers.
- controller_clk_out_enable  output  1  one-cycle shift strobe to both controllers.
- controller_1_buttons_out  output  BITS  published buttons, controller 1, active-high.
- controller_2_buttons_out  output  BITS  published buttons, controller 2, active-high.
- buttons_valid  output  1  one-cycle pulse when new values are published.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rst_B=0):
  - FSM to IDLE; all outputs 0.
  - Shift registers, counters, pending flag and vsync history all cleared.
  - Reset asserted mid-poll aborts the poll; buttons_out return to 0.
- Edge detect: vsync is registered once; frame_req = prev & ~vsync, i.e. it fires in the cycle after the falling edge is sampled.
- IDLE:
  - On frame_req or pending: next state LATCH, latch_cnt=0, pending cleared.
  - controller_latch goes high on the entry edge.
- LATCH:
  - controller_latch held at 1.
  - Each tick increments latch_cnt.
  - On the tick with latch_cnt==LATCH_TICKS-1: latch drops to 0 at that edge, state goes to SAMPLE, bit_cnt=0.
- SAMPLE:
  - On each tick, shift ~data_1_in_B and ~data_2_in_B into the shift-register LSBs.
    - Shift is left, so the first bit sampled ends in bit BITS-1 (MSB first).
  - If bit_cnt==BITS-1: state goes to DONE; no shift strobe is issued.
  - Otherwise: controller_clk_out_enable is asserted for exactly the next clk_5 cycle (registered), then bit_cnt++.
  - Exactly BITS-1 strobes are issued per poll.
- DONE, one cycle:
  - Both buttons_out load from the shift registers in the same edge.
  - buttons_valid pulses for that cycle.
  - Next state is LATCH if pending is set, otherwise IDLE.
- buttons_out change only in DONE; they are stable at all other times.
- frame_req while not IDLE sets pending (single-depth, not counted). Further requests are dropped.
- frame_req in the same cycle as DONE: the request is honoured (next state LATCH).
- Tick and frame_req in the same IDLE cycle: that tick is not counted toward latch_cnt.
- Ticks in IDLE or DONE are ignored.
- Latency, frame_req to buttons_valid: LATCH_TICKS + BITS ticks, plus 2 clk_5 cycles.

Optional Feature:
- Macro: CONTROLLER_POLLER_DEBOUNCE_EN.
- Defined:
  - The previous raw poll result per controller is kept.
  - In DONE, each output bit updates only where the new raw bit equals the previous raw bit; other bits hold.
  - buttons_valid still pulses every poll.
  - Raw-history registers reset to 0.
- Undefined: outputs take the raw poll result directly; no history registers exist.

Test Plan:
- Basic poll: bench controllers hold 8'b10001001 / 8'b00100110, LATCH_TICKS=2, tick every 100 cycles, one vsync falling edge -> controller_latch high for 2 ticks; exactly 7 controller_clk_out_enable pulses; buttons_out = 8'h89 / 8'h26 with one buttons_valid pulse at LATCH_TICKS+BITS ticks + 2 cycles after frame_req.
- Atomicity: controller 1 inputs change to 8'h00 mid-SAMPLE -> buttons_out stay 8'h89 until DONE, then change in a single cycle to the assembled mix value; never partially updated.
- Pending request: second vsync falling edge during SAMPLE -> after DONE, FSM goes straight to LATCH; third edge in the same poll is dropped; exactly 2 buttons_valid pulses total.
- Reset mid-poll: rst_B low for 3 cycles during bit 4 -> latch=0, strobe=0, busy=0, buttons_out=0 immediately; next vsync edge gives a full correct poll.
- Debounce (macro defined): poll 1 with 8'h89 -> outputs 8'h00; poll 2 with 8'h89 -> outputs 8'h89; poll 3 with 8'h88 -> outputs 8'h89; poll 4 with 8'h88 -> outputs 8'h88.
- Boundary, tick period 2 cycles: polls complete correctly; strobe never coincides with a sample tick.
